// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a registered
// carry, LSB first, WIDTH cycles per operation plus one DONE cycle.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             a_bit;
  logic             b_bit;
  logic             s_bit;
  logic             c_d;
  logic             last;
  logic [WIDTH-1:0] res_d;

  // Operands shift right, so the live bit is always at position 0.
  always_comb begin
    a_bit = a_q[0];
    b_bit = b_q[0];
    s_bit = a_bit ^ b_bit ^ c_q;
    c_d   = (a_bit & b_bit) | (c_q & (a_bit ^ b_bit));
    res_d = res_q | (WIDTH'(s_bit) << cnt_q);
    last  = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            c_q     <= sub | cin;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            sum_q   <= res_d;
            cout_q  <= c_d;
            ovf_q   <= c_q ^ c_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: WIDTH=8 and WIDTH=1 instances
// checked against an arithmetic reference model.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st8, sb8, ci8;
  logic [7:0] a8, b8;
  logic       bz8, dn8, co8, ov8;
  logic [7:0] s8;

  logic       st1, sb1, ci1;
  logic [0:0] a1, b1;
  logic       bz1, dn1, co1, ov1;
  logic [0:0] s1;

  serial_addsub #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .sub(sb8),
    .a(a8), .b(b8), .cin(ci8), .busy(bz8), .done(dn8),
    .sum(s8), .cout(co8), .ovf(ov8)
  );

  serial_addsub #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .sub(sb1),
    .a(a1), .b(b1), .cin(ci1), .busy(bz1), .done(dn1),
    .sum(s1), .cout(co1), .ovf(ov1)
  );

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t hv8, hv1, m8, m1;
  int n_chk = 0;
  int n_fail = 0;

  function automatic longint sgn(longint x, int w);
    longint half = longint'(1) << (w - 1);
    return (x >= half) ? x - (longint'(1) << w) : x;
  endfunction

  // Plain integer arithmetic: modular result, unsigned carry/no-borrow,
  // and signed overflow as "true signed result out of range".
  function automatic exp_t model(int w, logic [7:0] a, logic [7:0] b,
                                 logic sb, logic ci);
    exp_t   e;
    longint m = (longint'(1) << w) - 1;
    longint ua = longint'(a) & m;
    longint ub = longint'(b) & m;
    longint t, r;
    longint lo = -(longint'(1) << (w - 1));
    longint hi = (longint'(1) << (w - 1)) - 1;
    if (sb) begin
      t   = ua - ub;
      r   = sgn(ua, w) - sgn(ub, w);
      e.c = (ua >= ub);
    end else begin
      t   = ua + ub + longint'(ci);
      r   = sgn(ua, w) + sgn(ub, w) + longint'(ci);
      e.c = (t > m);
    end
    e.s = 64'(t & m);
    e.o = (r < lo) || (r > hi);
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (dn8 === 1'b1) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 64'(dn8), 64'd0);
      end else begin
        m8 = q8.pop_front();
        chk("sum8", 64'(s8), m8.s);
        chk("cout8", 64'(co8), 64'(m8.c));
        chk("ovf8", 64'(ov8), 64'(m8.o));
      end
    end
  end

  always @(negedge clk) begin
    if (dn1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("done1_unexpected", 64'(dn1), 64'd0);
      end else begin
        m1 = q1.pop_front();
        chk("sum1", 64'(s1), m1.s);
        chk("cout1", 64'(co1), 64'(m1.c));
        chk("ovf1", 64'(ov1), 64'(m1.o));
      end
    end
  end

  task automatic scramble(bit w1);
    if (w1) begin
      a1 = 1'($urandom); b1 = 1'($urandom);
      sb1 = 1'($urandom); ci1 = 1'($urandom);
    end else begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      sb8 = 1'($urandom); ci8 = 1'($urandom);
    end
  endtask

  task automatic issue(bit w1, logic [7:0] a, logic [7:0] b,
                       logic sb, logic ci, bit keep, bit restart);
    int   w = w1 ? 1 : 8;
    exp_t e = model(w, a, b, sb, ci);
    exp_t h = w1 ? hv1 : hv8;
    @(negedge clk);
    if (w1) begin
      a1 = a[0:0]; b1 = b[0:0]; sb1 = sb; ci1 = ci; st1 = 1'b1;
      q1.push_back(e);
    end else begin
      a8 = a; b8 = b; sb8 = sb; ci8 = ci; st8 = 1'b1;
      q8.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      if (w1) st1 = 1'b0;
      else st8 = 1'b0;
    end
    scramble(w1);
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      chk("busy_run", 64'(w1 ? bz1 : bz8), 64'd1);
      chk("done_run", 64'(w1 ? dn1 : dn8), 64'd0);
      chk("sum_hold", w1 ? 64'(s1) : 64'(s8), h.s);
      if (restart && k == 3) begin
        st8 = 1'b1;
        scramble(1'b0);
      end
      if (restart && k == 4 && !keep) st8 = 1'b0;
    end
    @(negedge clk);
    chk("busy_done", 64'(w1 ? bz1 : bz8), 64'd0);
    chk("done_pulse", 64'(w1 ? dn1 : dn8), 64'd1);
    if (w1) hv1 = e;
    else hv8 = e;
  endtask

  task automatic abort_by_reset();
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; sb8 = 1'b0; ci8 = 1'b0; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_pre_rst", 64'(bz8), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(bz8), 64'd0);
    chk("rst_done", 64'(dn8), 64'd0);
    chk("rst_sum", 64'(s8), 64'd0);
    chk("rst_cout", 64'(co8), 64'd0);
    chk("rst_ovf", 64'(ov8), 64'd0);
    hv8 = '{s: 64'd0, c: 1'b0, o: 1'b0};
    hv1 = '{s: 64'd0, c: 1'b0, o: 1'b0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk("no_done_after_rst", 64'(dn8), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    st8 = 0; sb8 = 0; ci8 = 0; a8 = 0; b8 = 0;
    st1 = 0; sb1 = 0; ci1 = 0; a1 = 0; b1 = 0;
    hv8 = '{s: 64'd0, c: 1'b0, o: 1'b0};
    hv1 = '{s: 64'd0, c: 1'b0, o: 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_busy8", 64'(bz8), 64'd0);
    chk("rst_done8", 64'(dn8), 64'd0);
    chk("rst_sum8", 64'(s8), 64'd0);
    chk("rst_cout8", 64'(co8), 64'd0);
    chk("rst_ovf8", 64'(ov8), 64'd0);
    chk("rst_busy1", 64'(bz1), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, 0);
    issue(0, 8'h7F, 8'h00, 1'b0, 1'b1, 0, 0);
    issue(0, 8'h05, 8'h07, 1'b1, 1'b1, 0, 0);
    issue(0, 8'h80, 8'h01, 1'b1, 1'b0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      issue(1, {7'd0, v[2]}, {7'd0, v[1]}, 1'b0, v[0], i < 7, 0);
    end

    for (int n = 0; n < 6; n++)
      issue(0, 8'($urandom), 8'($urandom), 1'($urandom),
            1'($urandom), n < 5, 0);

    issue(0, 8'h5A, 8'h3C, 1'b0, 1'b1, 0, 1);
    @(negedge clk);
    chk("no_queued_busy", 64'(bz8), 64'd0);
    @(negedge clk);
    chk("no_queued_busy2", 64'(bz8), 64'd0);

    for (int n = 0; n < 20; n++)
      issue(0, 8'($urandom), 8'($urandom), 1'($urandom),
            1'($urandom), 0, 0);
    for (int n = 0; n < 6; n++)
      issue(1, 8'($urandom), 8'($urandom), 1'($urandom),
            1'($urandom), 0, 0);

    abort_by_reset();
    issue(0, 8'h0A, 8'h14, 1'b0, 1'b0, 0, 0);

    repeat (3) @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  launch request, sampled only in IDLE.
REQ-005 SHALL have port: sub  input  1  0 = add, 1 = subtract; sampled with start.
REQ-006 SHALL have port: a  input  WIDTH  operand A, sampled with start.
REQ-007 SHALL have port: b  input  WIDTH  operand B, sampled with start.
REQ-008 SHALL have port: cin  input  1  carry-in for add, sampled with start; ignored when sub=1.
REQ-009 SHALL have port: busy  output  1  high while bits are being processed.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when result valid.
REQ-011 SHALL have port: sum  output  WIDTH  result.
REQ-012 SHALL have port: cout  output  1  carry-out; for subtract, 1 = no borrow (a >= b unsigned).
REQ-013 SHALL have port: ovf  output  1  two's-complement signed overflow.

Function
REQ-014 SHALL compute the result bit-serially, LSB first, one bit per clock, through a single 1-bit full-adder cell and a registered carry.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE with start=1 SHALL latch a, b XOR {WIDTH{sub}}, set the initial carry to (sub ? 1 : cin), clear the bit counter, and go to RUN.
REQ-017 RUN SHALL process one bit per cycle and shift the sum bit into the result register at bit position counter.
REQ-018 RUN SHALL last exactly WIDTH cycles, then go to DONE.
REQ-019 DONE SHALL last one cycle, then return to IDLE.
REQ-020 busy SHALL be 1 exactly in RUN.
REQ-021 done SHALL be 1 exactly in DONE.
REQ-022 Latency: with start high at edge N, busy SHALL be high over edges N+1..N+WIDTH, and done SHALL be high in the cycle after edge N+WIDTH.
REQ-023 sum, cout and ovf SHALL update only on entry to DONE and SHALL hold until the next DONE or reset.
REQ-024 sum SHALL equal (a + b + cin) mod 2^WIDTH for add, and (a - b) mod 2^WIDTH for subtract.
REQ-025 cout SHALL be the final carry out of the MSB stage.
REQ-026 ovf SHALL be (carry into MSB) XOR (carry out of MSB).
REQ-027 start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-028 start held high continuously SHALL launch a new operation from each IDLE visit, giving back-to-back operations every WIDTH+2 cycles.
REQ-029 Changes on a, b, sub or cin after the launch edge SHALL NOT affect the operation in flight.
REQ-030 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide, so that WIDTH=1 is legal (RUN lasts one cycle).

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal carry=0 and counter=0.
REQ-032 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and the first start after rst_n deasserts SHALL behave as from power-up.
REQ-033 start SHALL NOT be acted on at the rising edge coincident with the rst_n deassertion edge if both change in the same cycle; the bench drives start at least one cycle after reset release.

Verification
REQ-034 WIDTH=8, add: a=8'hFF, b=8'h01, cin=0 -> after 8 busy cycles, done pulse with sum=8'h00, cout=1, ovf=0.
REQ-035 WIDTH=8, add: a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, cout=0, ovf=1.
REQ-036 WIDTH=8, subtract: a=8'h05, b=8'h07, cin=1 (ignored) -> sum=8'hFE, cout=0, ovf=0; then a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
REQ-037 WIDTH=1: exhaustive check of all 8 {a,b,cin} combinations in add mode -> {cout,sum} equals a+b+cin, each with busy high for 1 cycle and done on the following cycle.
REQ-038 WIDTH=8: start pulsed again on the 3rd busy cycle with different operands -> first result unaffected, no second operation launched, busy drops after cycle 8.
REQ-039 WIDTH=8: rst_n pulsed low on the 4th busy cycle -> busy, done, sum, cout and ovf go to 0 asynchronously, and no done follows; a subsequent start with a=8'h0A, b=8'h14 -> sum=8'h1E.
